// File: rtl/disp_feed_if.sv
// Signal bundle between the CPU debug sources, the push-buttons and the
// seven-segment display multiplexer.
interface disp_feed_if;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_addr_i;
  logic        btn_sel_i;
  logic        btn_half_i;
  logic        freeze_i;
  logic [31:0] disp_data_o;
  logic        lowOrHigh_o;
  logic        scan_clk_o;
  logic [1:0]  src_o;

  modport master (
    output pc_i, inst_i, wdata_i, mem_addr_i, btn_sel_i, btn_half_i, freeze_i,
    input  disp_data_o, lowOrHigh_o, scan_clk_o, src_o
  );

  modport slave (
    input  pc_i, inst_i, wdata_i, mem_addr_i, btn_sel_i, btn_half_i, freeze_i,
    output disp_data_o, lowOrHigh_o, scan_clk_o, src_o
  );
endinterface

// File: rtl/disp_feed.sv
// Display feeder: debounced source/halfword buttons, registered display word
// and the free-running digit-scan clock for the seven-segment multiplexer.
module disp_feed #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic         clk,
  input  logic         rst,
  disp_feed_if.slave   bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    SRC_PC   = 2'd0,
    SRC_INST = 2'd1,
    SRC_WB   = 2'd2,
    SRC_MEM  = 2'd3
  } src_t;

  // Index 0 is the source-select button, index 1 the halfword button.
  logic [1:0]         btn_raw_s;
  logic [1:0]         sync1_r;
  logic [1:0]         sync2_r;
  logic [1:0]         stable_r;
  logic [1:0]         stable_d_r;
  logic [1:0]         pulse_r;
  logic [1:0][DW-1:0] cnt_r;

  src_t        state_r;
  src_t        state_next_s;
  logic        sel_pulse_s;
  logic        half_pulse_s;
  logic        src_changed_r;
  logic        load_en_s;
  logic [31:0] sel_data_s;
  logic [31:0] disp_data_r;
  logic        low_r;
  logic [SW-1:0] scan_cnt_r;
  logic        scan_clk_r;

  assign btn_raw_s    = {bus.btn_half_i, bus.btn_sel_i};
  assign sel_pulse_s  = pulse_r[0];
  assign half_pulse_s = pulse_r[1];

  // Synchronize, debounce and rising-edge detect both buttons
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r    <= 2'b00;
      sync2_r    <= 2'b00;
      stable_r   <= 2'b00;
      stable_d_r <= 2'b00;
      pulse_r    <= 2'b00;
      cnt_r      <= '0;
    end else begin
      sync1_r    <= btn_raw_s;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      pulse_r    <= stable_r & ~stable_d_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == DB_MAX) begin
          stable_r[i] <= sync2_r[i];
          cnt_r[i]    <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + {{(DW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Source state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= SRC_PC;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Source advance on each select pulse, wrapping after the memory address
  always_comb begin
    state_next_s = state_r;
    if (sel_pulse_s) begin
      case (state_r)
        SRC_PC:   state_next_s = SRC_INST;
        SRC_INST: state_next_s = SRC_WB;
        SRC_WB:   state_next_s = SRC_MEM;
        SRC_MEM:  state_next_s = SRC_PC;
        default:  state_next_s = SRC_PC;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Debug-value mux for the current source
  always_comb begin
    sel_data_s = bus.pc_i;
    case (state_r)
      SRC_PC:   sel_data_s = bus.pc_i;
      SRC_INST: sel_data_s = bus.inst_i;
      SRC_WB:   sel_data_s = bus.wdata_i;
      SRC_MEM:  sel_data_s = bus.mem_addr_i;
      default:  sel_data_s = bus.pc_i;
    endcase
  end

  // A source change forces one load even while frozen
  assign load_en_s = ~bus.freeze_i | src_changed_r;

  // Display word, halfword select and source-change flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_changed_r <= 1'b0;
      disp_data_r   <= 32'h0000_0000;
      low_r         <= 1'b0;
    end else begin
      src_changed_r <= sel_pulse_s;
      if (load_en_s) begin
        disp_data_r <= sel_data_s;
      end
      if (sel_pulse_s) begin
        low_r <= 1'b0;
      end else if (half_pulse_s) begin
        low_r <= ~low_r;
      end
    end
  end

  // Free-running scan divider, toggling the scan clock on each wrap
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_r <= '0;
      scan_clk_r <= 1'b0;
    end else if (scan_cnt_r == SCAN_MAX) begin
      scan_cnt_r <= '0;
      scan_clk_r <= ~scan_clk_r;
    end else begin
      scan_cnt_r <= scan_cnt_r + {{(SW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.disp_data_o = disp_data_r;
  assign bus.lowOrHigh_o = low_r;
  assign bus.scan_clk_o  = scan_clk_r;
  assign bus.src_o       = state_r;

endmodule

// File: tb/tb_disp_feed.sv
// Self-checking bench for disp_feed: directed scenarios with fixed expectations
// plus randomized button/data/freeze/reset traffic against a reference model.
module tb_disp_feed;
  localparam int DB = 4;
  localparam int SD = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  disp_feed_if bus ();

  disp_feed #(.DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: a button level is accepted after DB consecutive edges
  // where the level seen two edges late differs from the accepted one; an
  // accepted press acts two edges later.
  logic [1:0]  m_d1, m_d2, m_st, m_f1, m_f2;
  int          m_run [2];
  logic [1:0]  m_src;
  logic        m_low, m_scan, m_chg;
  logic [31:0] m_disp;
  int          m_n;

  always @(posedge clk) begin : ref_model
    logic [1:0]  acc;
    logic [1:0]  st_n;
    int          run_n [2];
    logic [31:0] vals [4];
    if (rst === 1'b0) begin
      m_d1 <= 2'b00; m_d2 <= 2'b00; m_st <= 2'b00; m_f1 <= 2'b00; m_f2 <= 2'b00;
      m_run <= '{0, 0};
      m_src <= 2'd0; m_low <= 1'b0; m_scan <= 1'b0; m_chg <= 1'b0;
      m_disp <= 32'h0; m_n <= 0;
    end else begin
      vals = '{bus.pc_i, bus.inst_i, bus.wdata_i, bus.mem_addr_i};
      st_n = m_st;
      acc  = 2'b00;
      for (int b = 0; b < 2; b++) begin
        run_n[b] = (m_d2[b] != m_st[b]) ? m_run[b] + 1 : 0;
        if (run_n[b] == DB) begin
          st_n[b]  = m_d2[b];
          run_n[b] = 0;
          acc[b]   = m_d2[b];
        end
      end
      m_run <= run_n;
      m_st  <= st_n;
      m_d2  <= m_d1;
      m_d1  <= {bus.btn_half_i, bus.btn_sel_i};
      m_f1  <= acc;
      m_f2  <= m_f1;
      if (!bus.freeze_i || m_chg) m_disp <= vals[m_src];
      m_chg <= m_f2[0];
      if (m_f2[0]) begin
        m_src <= m_src + 2'd1;
        m_low <= 1'b0;
      end else if (m_f2[1]) begin
        m_low <= ~m_low;
      end
      m_n    <= m_n + 1;
      m_scan <= (((m_n + 1) / SD) % 2) == 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pc_i = 32'h0; bus.inst_i = 32'h0; bus.wdata_i = 32'h0; bus.mem_addr_i = 32'h0;
    bus.btn_sel_i = 1'b0; bus.btn_half_i = 1'b0; bus.freeze_i = 1'b0;
    cyc(2);
    rst = 1'b1;
    n_total++;
    if ({bus.disp_data_o, bus.lowOrHigh_o, bus.scan_clk_o, bus.src_o} !== 36'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {bus.disp_data_o, bus.lowOrHigh_o, bus.scan_clk_o, bus.src_o});
    else n_pass++;
    for (int n = 1; n <= 12; n++) begin
      logic exp_scan;
      cyc(1);
      exp_scan = ((n / SD) % 2) == 1;
      n_total++;
      if (bus.scan_clk_o !== exp_scan)
        $display("FAIL scan_edge%0d: got %b want %b", n, bus.scan_clk_o, exp_scan);
      else n_pass++;
    end
  endtask

  task automatic test_source_cycling();
    logic [1:0]  exp_src  [4];
    logic [31:0] exp_disp [4];
    logic [1:0]  prev;
    int          lat;
    exp_src  = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_disp = '{32'h8C22_0004, 32'hDEAD_BEEF, 32'h1001_0000, 32'h0040_0010};
    bus.pc_i = 32'h0040_0010; bus.inst_i = 32'h8C22_0004;
    bus.wdata_i = 32'hDEAD_BEEF; bus.mem_addr_i = 32'h1001_0000;
    cyc(2);
    for (int p = 0; p < 4; p++) begin
      prev = bus.src_o;
      bus.btn_sel_i = 1'b1;
      cyc(1);
      lat = 0;
      for (int n = 1; n <= 12 && lat == 0; n++) begin
        cyc(1);
        if (bus.src_o !== prev) lat = n;
      end
      n_total++;
      if (lat !== 7) $display("FAIL sel_latency%0d: got %0d want 7", p, lat);
      else n_pass++;
      n_total++;
      if (bus.src_o !== exp_src[p]) $display("FAIL src_step%0d: got %0d want %0d", p, bus.src_o, exp_src[p]);
      else n_pass++;
      cyc(1);
      n_total++;
      if (bus.disp_data_o !== exp_disp[p])
        $display("FAIL disp_step%0d: got %h want %h", p, bus.disp_data_o, exp_disp[p]);
      else n_pass++;
      cyc(1);
      bus.btn_sel_i = 1'b0;
      cyc(10);
    end
  endtask

  task automatic test_bounce();
    int   lat;
    int   toggles;
    logic prev;
    prev = bus.lowOrHigh_o;
    toggles = 0;
    lat = 0;
    bus.btn_half_i = 1'b1; cyc(3);
    bus.btn_half_i = 1'b0; cyc(1);
    bus.btn_half_i = 1'b1; cyc(1);
    n_total++;
    if (bus.lowOrHigh_o !== 1'b0) $display("FAIL bounce_early: got %b want 0", bus.lowOrHigh_o);
    else n_pass++;
    for (int n = 1; n <= 15; n++) begin
      cyc(1);
      if (bus.lowOrHigh_o !== prev) begin
        toggles++;
        if (lat == 0) lat = n;
        prev = bus.lowOrHigh_o;
      end
    end
    n_total++;
    if (lat !== 7) $display("FAIL bounce_latency: got %0d want 7", lat);
    else n_pass++;
    n_total++;
    if (toggles !== 1) $display("FAIL bounce_toggles: got %0d want 1", toggles);
    else n_pass++;
    bus.btn_half_i = 1'b0;
    cyc(10);
    n_total++;
    if (bus.lowOrHigh_o !== 1'b1) $display("FAIL half_release: got %b want 1", bus.lowOrHigh_o);
    else n_pass++;
  endtask

  task automatic test_freeze();
    int lat;
    bus.pc_i = 32'h0000_0100;
    cyc(2);
    n_total++;
    if (bus.disp_data_o !== 32'h0000_0100) $display("FAIL freeze_pre: got %h want 00000100", bus.disp_data_o);
    else n_pass++;
    bus.freeze_i = 1'b1;
    bus.pc_i = 32'h0000_0200;
    cyc(3);
    n_total++;
    if (bus.disp_data_o !== 32'h0000_0100) $display("FAIL freeze_hold: got %h want 00000100", bus.disp_data_o);
    else n_pass++;
    bus.inst_i = 32'hAAAA_0001;
    bus.btn_sel_i = 1'b1;
    cyc(1);
    lat = 0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      cyc(1);
      if (bus.src_o !== 2'd0) lat = n;
    end
    n_total++;
    if (lat !== 7 || bus.disp_data_o !== 32'h0000_0100 || bus.lowOrHigh_o !== 1'b0)
      $display("FAIL freeze_sel_edge: got lat=%0d disp=%h low=%b want 7 00000100 0",
               lat, bus.disp_data_o, bus.lowOrHigh_o);
    else n_pass++;
    cyc(1);
    n_total++;
    if (bus.disp_data_o !== 32'hAAAA_0001) $display("FAIL freeze_load_once: got %h want aaaa0001", bus.disp_data_o);
    else n_pass++;
    bus.btn_sel_i = 1'b0;
    bus.inst_i = 32'hBBBB_0002;
    cyc(10);
    n_total++;
    if (bus.disp_data_o !== 32'hAAAA_0001) $display("FAIL freeze_ignore: got %h want aaaa0001", bus.disp_data_o);
    else n_pass++;
    bus.freeze_i = 1'b0;
    cyc(1);
    n_total++;
    if (bus.disp_data_o !== 32'hBBBB_0002) $display("FAIL unfreeze: got %h want bbbb0002", bus.disp_data_o);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int   lat;
    logic prev_low;
    bus.btn_half_i = 1'b1; cyc(10);
    bus.btn_half_i = 1'b0; cyc(10);
    n_total++;
    if (bus.lowOrHigh_o !== 1'b1) $display("FAIL simul_setup: got %b want 1", bus.lowOrHigh_o);
    else n_pass++;
    bus.btn_sel_i = 1'b1;
    bus.btn_half_i = 1'b1;
    cyc(1);
    lat = 0;
    prev_low = bus.lowOrHigh_o;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      prev_low = bus.lowOrHigh_o;
      cyc(1);
      if (bus.src_o !== 2'd1) lat = n;
    end
    n_total++;
    if (lat !== 7 || bus.src_o !== 2'd2 || bus.lowOrHigh_o !== 1'b0 || prev_low !== 1'b1)
      $display("FAIL simul_press: got lat=%0d src=%0d low=%b prev_low=%b want 7 2 0 1",
               lat, bus.src_o, bus.lowOrHigh_o, prev_low);
    else n_pass++;
    bus.btn_sel_i = 1'b0;
    bus.btn_half_i = 1'b0;
    cyc(10);
  endtask

  task automatic test_reset_mid_debounce();
    int lat;
    bus.btn_sel_i = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    n_total++;
    if ({bus.disp_data_o, bus.lowOrHigh_o, bus.src_o} !== 35'd0)
      $display("FAIL midreset_state: got %h want 0", {bus.disp_data_o, bus.lowOrHigh_o, bus.src_o});
    else n_pass++;
    cyc(1);
    lat = 0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      cyc(1);
      if (bus.src_o !== 2'd0) lat = n;
    end
    n_total++;
    if (lat !== 7 || bus.src_o !== 2'd1)
      $display("FAIL midreset_redebounce: got lat=%0d src=%0d want 7 1", lat, bus.src_o);
    else n_pass++;
    bus.btn_sel_i = 1'b0;
    cyc(10);
  endtask

  task automatic test_random();
    int hs = 0;
    int hh = 0;
    for (int c = 0; c < 800; c++) begin
      if (hs == 0) begin
        bus.btn_sel_i = 1'($urandom_range(0, 1));
        hs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
      end else hs--;
      if (hh == 0) begin
        bus.btn_half_i = 1'($urandom_range(0, 1));
        hh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
      end else hh--;
      bus.pc_i = $urandom; bus.inst_i = $urandom;
      bus.wdata_i = $urandom; bus.mem_addr_i = $urandom;
      if ($urandom_range(0, 15) == 0) bus.freeze_i = ~bus.freeze_i;
      rst = ($urandom_range(0, 199) != 0);
      cyc(1);
      n_total++;
      if ({bus.disp_data_o, bus.lowOrHigh_o, bus.scan_clk_o, bus.src_o} !== {m_disp, m_low, m_scan, m_src})
        $display("FAIL random_c%0d: got disp=%h low=%b scan=%b src=%0d want disp=%h low=%b scan=%b src=%0d",
                 c, bus.disp_data_o, bus.lowOrHigh_o, bus.scan_clk_o, bus.src_o,
                 m_disp, m_low, m_scan, m_src);
      else n_pass++;
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_source_cycling();
    test_bounce();
    test_freeze();
    test_simultaneous();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
